// File: rtl/uart_hex_dumper_pkg.sv
// Shared constants, FSM encoding and the nibble-to-ASCII helper for the hex dumper.
package uart_hex_dumper_pkg;

  localparam logic [7:0] CHR_CR = 8'h0D;
  localparam logic [7:0] CHR_LF = 8'h0A;
  localparam logic [7:0] CHR_SP = 8'h20;
  localparam logic [7:0] CHR_0  = 8'h30;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_STROBE    = 3'd2,
    ST_WAIT_ACT  = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_WAIT_CLR  = 3'd5
  } state_t;

  // Render one nibble as an ASCII hex digit; letter case chosen by 'upper'.
  function automatic logic [7:0] hex_char(input logic [3:0] nib, input logic upper);
    logic [7:0] letter_base;
    letter_base = upper ? 8'h41 : 8'h61;
    if (nib < 4'd10) begin
      hex_char = CHR_0 + {4'd0, nib};
    end else begin
      hex_char = letter_base + {4'd0, nib} - 8'd10;
    end
  endfunction

endpackage

// File: rtl/uart_hex_dumper_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; pointers carry one extra wrap bit
// so full and empty are distinguishable without a counter.
module sync_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             do_wr_s;
  logic             do_rd_s;

  assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty   = (wr_ptr_r == rd_ptr_r);
  assign do_wr_s = wr_en && !full;
  assign do_rd_s = rd_en && !empty;
  assign rd_data = mem_r[rd_ptr_r[AW-1:0]];

  // Storage array: written on accepted pushes only, no reset needed.
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end
  end

  // Read and write pointers, wrapping naturally modulo 2*DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_wr_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (do_rd_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_hex_dumper.sv
// Byte-stream to ASCII hex dumper feeding a UART transmitter one char at a time.
// Each byte becomes HI, LO and either a space or CR LF at end of frame / line.
module uart_hex_dumper #(
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned BYTES_PER_LINE = 16,
  parameter bit          UPPERCASE      = 1'b1
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_Data_DV,
  input  logic [7:0] i_Data_Byte,
  input  logic       i_Data_Last,
  output logic       o_Data_Ready,
  output logic       o_Overflow,
  output logic       o_TX_DV,
  output logic [7:0] o_TX_Byte,
  input  logic       i_TX_Active,
  input  logic       i_TX_Done,
  output logic       o_Busy
);
  import uart_hex_dumper_pkg::*;

  localparam logic [8:0] BPL_W = 9'(BYTES_PER_LINE);

  state_t     state_r;
  logic [7:0] byte_r;
  logic       eol_r;
  logic [1:0] idx_r;
  logic [7:0] line_cnt_r;
  logic       tx_dv_r;
  logic [7:0] tx_byte_r;
  logic       overflow_r;

  logic       fifo_full_s;
  logic       fifo_empty_s;
  logic [8:0] fifo_rd_s;
  logic       push_s;
  logic       pop_s;
  logic       eol_s;
  logic [1:0] last_idx_s;
  logic [7:0] char_s;

  assign push_s       = i_Data_DV && !fifo_full_s;
  assign pop_s        = (state_r == ST_IDLE) && !fifo_empty_s;
  assign eol_s        = fifo_rd_s[8] || (({1'b0, line_cnt_r} + 9'd1) == BPL_W);
  assign last_idx_s   = eol_r ? 2'd3 : 2'd2;
  assign o_Data_Ready = !fifo_full_s;
  assign o_Busy       = !fifo_empty_s || (state_r != ST_IDLE);
  assign o_TX_DV      = tx_dv_r;
  assign o_TX_Byte    = tx_byte_r;
  assign o_Overflow   = overflow_r;

  sync_fifo #(
    .WIDTH (9),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_Clock),
    .rst_n   (i_Reset_n),
    .wr_en   (push_s),
    .wr_data ({i_Data_Last, i_Data_Byte}),
    .rd_en   (pop_s),
    .rd_data (fifo_rd_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // Select the character for the current position in the per-byte sequence.
  always_comb begin
    char_s = 8'h00;
    case (idx_r)
      2'd0:    char_s = hex_char(byte_r[7:4], UPPERCASE);
      2'd1:    char_s = hex_char(byte_r[3:0], UPPERCASE);
      2'd2:    char_s = eol_r ? CHR_CR : CHR_SP;
      2'd3:    char_s = CHR_LF;
      default: char_s = 8'h00;
    endcase
  end

  // Sticky overflow flag: any valid byte offered while the FIFO is full.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      overflow_r <= 1'b0;
    end else if (i_Data_DV && fifo_full_s) begin
      overflow_r <= 1'b1;
    end
  end

  // Char sequencer: waits for Done to fall before the next strobe so every
  // strobe lands while the transmitter is idle.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_r    <= ST_IDLE;
      byte_r     <= 8'h00;
      eol_r      <= 1'b0;
      idx_r      <= 2'd0;
      line_cnt_r <= 8'd0;
      tx_dv_r    <= 1'b0;
      tx_byte_r  <= 8'h00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          tx_dv_r <= 1'b0;
          if (!fifo_empty_s) begin
            byte_r     <= fifo_rd_s[7:0];
            eol_r      <= eol_s;
            idx_r      <= 2'd0;
            line_cnt_r <= eol_s ? 8'd0 : (line_cnt_r + 8'd1);
            state_r    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          tx_byte_r <= char_s;
          tx_dv_r   <= 1'b1;
          state_r   <= ST_STROBE;
        end
        ST_STROBE: begin
          tx_dv_r <= 1'b0;
          state_r <= ST_WAIT_ACT;
        end
        ST_WAIT_ACT: begin
          if (i_TX_Active) begin
            state_r <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (i_TX_Done) begin
            state_r <= ST_WAIT_CLR;
          end
        end
        ST_WAIT_CLR: begin
          if (!i_TX_Done) begin
            if (idx_r < last_idx_s) begin
              idx_r   <= idx_r + 2'd1;
              state_r <= ST_LOAD;
            end else begin
              state_r <= ST_IDLE;
            end
          end
        end
        default: begin
          tx_dv_r <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
